// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, capping each grant at MAX_BURST writes.
// Define FIFO_ARB_STALL_CNT_EN to build the saturating stall counter; otherwise stall_count is tied to 0.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 fifo_full,
    output logic                 fifo_write,
    output logic [7:0]           fifo_data_in,
    output logic                 busy,
    output logic [15:0]          stall_count
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDXW-1:0]    rr_ptr, rr_ptr_d, g_idx, g_next, start, sel, cand;
    logic [3:0]         burst_cnt, burst_cnt_d;
    logic               req_g, burst_last, release_g, any_req;
    logic [7:0]         data_g;
    int                 srch;

    always_comb begin
        g_idx  = '0;
        req_g  = 1'b0;
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx  = IDXW'(i);
                req_g  = req[i];
                data_g = req_data[i*8 +: 8];
            end
        end
    end

    assign g_next = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
    // A release searches from the requester after g, so g itself is checked last.
    assign start  = (state == IDLE) ? rr_ptr : g_next;

    // Descending scan: the lowest offset from start that is requesting wins.
    always_comb begin
        sel  = start;
        cand = '0;
        srch = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            srch = int'(start) + k;
            if (srch >= NUM_REQ) srch = srch - NUM_REQ;
            cand = IDXW'(srch);
            if (req[cand]) sel = cand;
        end
    end

    assign any_req      = |req;
    assign busy         = (state == BURST);
    assign fifo_write   = busy && req_g && !fifo_full;
    assign ack          = fifo_write ? grant : '0;
    assign fifo_data_in = fifo_write ? data_g : 8'h00;
    assign burst_last   = (({1'b0, burst_cnt} + 5'd1) == 5'(MAX_BURST));
    assign release_g    = !req_g || (fifo_write && burst_last);

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_d     = BURST;
                    grant_d     = ONE << sel;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (release_g) begin
                    rr_ptr_d    = g_next;
                    burst_cnt_d = '0;
                    if (any_req) begin
                        grant_d = ONE << sel;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (fifo_write) begin
                    burst_cnt_d = burst_cnt + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (any_req && fifo_full && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, all checked against a
// cycle-level model built from the arbitration rules (current owner, burst count, search pointer).
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   ack, grant;
    logic           fifo_full, fifo_write;
    logic [7:0]     fifo_data_in;
    logic           busy;
    logic [15:0]    stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    bit m_busy, m_wrote;
    int m_g, m_cnt, m_ptr, m_stall;

    logic [7:0]   log_q[$];
    logic [N-1:0] ack_q[$];

    fifo_write_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .fifo_full(fifo_full), .fifo_write(fifo_write),
        .fifo_data_in(fifo_data_in), .busy(busy), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_first(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_wrote = 1'b0;
        m_g = 0; m_cnt = 0; m_ptr = 0; m_stall = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [N-1:0] eg, ea;
        logic         ew;
        logic [7:0]   ed;
        #1;
        eg = '0;
        if (m_busy) eg[m_g] = 1'b1;
        ew = m_busy && req[m_g] && !fifo_full;
        ea = '0;
        if (ew) ea[m_g] = 1'b1;
        ed = ew ? req_data[m_g*8 +: 8] : 8'h00;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("fifo_write", 32'(fifo_write), 32'(ew));
        chk("ack", 32'(ack), 32'(ea));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(ed));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        if (fifo_write) begin
            log_q.push_back(fifo_data_in);
            ack_q.push_back(ack);
        end
        @(posedge clock);
        m_wrote = ew;
`ifdef FIFO_ARB_STALL_CNT_EN
        if (req != 0 && fifo_full && m_stall < 65535) m_stall++;
`endif
        if (!m_busy) begin
            if (req != 0) begin
                m_busy = 1'b1;
                m_g    = rr_first(req, m_ptr);
                m_cnt  = 0;
            end
        end else begin
            if (ew) m_cnt++;
            if (!req[m_g] || (ew && m_cnt == MB)) begin
                m_ptr = (m_g + 1) % N;
                m_cnt = 0;
                if (req != 0) m_g = rr_first(req, m_ptr);
                else          m_busy = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; req = '0; fifo_full = 1'b0; req_data = '0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] seq3 [3];
        int idx, acks;
        logic [N-1:0] r;

        // Reset with every requester asking
        reset_n = 1'b0; req = 4'b1111; req_data = 32'h44332211; fifo_full = 1'b0;
        model_reset();
        @(negedge clock); #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_write", 32'(fifo_write), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        #1 chk("first_grant", 32'(grant), 32'h1);

        // Requesters 0 and 2, FIFO never full: 4 x r0, 4 x r2, 4 x r0 back to back
        do_reset();
        req = 4'b0101; req_data = $urandom;
        ack_q.delete();
        for (int k = 0; k < 13; k++) begin
            req_data = $urandom;
            tick();
        end
        chk("rr_count", 32'(ack_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < ack_q.size(); i++)
            chk("rr_order", 32'(ack_q[i]), (i >= 4 && i < 8) ? 32'h4 : 32'h1);

        // Single requester 1 sends three bytes then drops
        do_reset();
        seq3[0] = 8'hA5; seq3[1] = 8'h3C; seq3[2] = 8'h7E;
        log_q.delete(); idx = 0; acks = 0;
        for (int k = 0; k < 6; k++) begin
            if (idx < 3) begin req = 4'b0010; req_data = {16'h0, seq3[idx], 8'h0}; end
            else         begin req = 4'b0000; req_data = '0; end
            #1 if (ack[1]) acks++;
            tick();
            if (m_wrote) idx++;
        end
        chk("single_count", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++)
            chk("single_data", 32'(log_q[i]), 32'(seq3[i]));
        chk("single_acks", 32'(acks), 32'd3);
        chk("single_idle", 32'(busy), 32'h0);

        // Five cycles of fifo_full in the middle of a burst
        do_reset();
        log_q.delete(); idx = 0;
        for (int k = 0; k < 20; k++) begin
            req = 4'b1000;
            req_data = {8'h10 + 8'(idx), 24'h0};
            fifo_full = (k >= 3 && k <= 7);
            tick();
            if (m_wrote) idx++;
        end
        fifo_full = 1'b0;
        chk("stall_count_writes", 32'(log_q.size()), 32'd14);
        for (int i = 0; i < log_q.size(); i++)
            chk("stall_data", 32'(log_q[i]), 32'(8'h10 + 8'(i)));

        // Async reset in the middle of a second burst, after rr_ptr has moved
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            req_data = $urandom;
            tick();
        end
        #2 chk("pre_rst_write", 32'(fifo_write), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_write", 32'(fifo_write), 32'h0);
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_ack", 32'(ack), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1; req = 4'b1111;
        tick();
        #1 chk("restart_r0", 32'(grant), 32'h1);

        // Ten stall cycles with requester 0
        do_reset();
        req = 4'b0001; fifo_full = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        #1;
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_ten", 32'(stall_count), 32'd10);
`else
        chk("stall_ten", 32'(stall_count), 32'd0);
`endif

        // Random traffic
        do_reset();
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            req       = r;
            req_data  = $urandom;
            fifo_full = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
